// File: rtl/sram_port_arbiter_if.sv
// Request/response and SRAM-port bundle for sram_port_arbiter.
// The slave modport is the arbiter's view; master is the requesters' and SRAM's view.
interface sram_port_arbiter_if;
   logic        inst_req;
   logic [31:0] inst_addr;
   logic        inst_addr_ok;
   logic        inst_data_ok;
   logic [31:0] inst_rdata;

   logic        data_req;
   logic        data_wr;
   logic [3:0]  data_wstrb;
   logic [31:0] data_addr;
   logic [31:0] data_wdata;
   logic        data_addr_ok;
   logic        data_data_ok;
   logic [31:0] data_rdata;

   logic        sram_en;
   logic [3:0]  sram_we;
   logic [31:0] sram_addr;
   logic [31:0] sram_wdata;
   logic [31:0] sram_rdata;

   modport slave (
      input  inst_req, inst_addr,
      output inst_addr_ok, inst_data_ok, inst_rdata,
      input  data_req, data_wr, data_wstrb, data_addr, data_wdata,
      output data_addr_ok, data_data_ok, data_rdata,
      output sram_en, sram_we, sram_addr, sram_wdata,
      input  sram_rdata
   );

   modport master (
      output inst_req, inst_addr,
      input  inst_addr_ok, inst_data_ok, inst_rdata,
      output data_req, data_wr, data_wstrb, data_addr, data_wdata,
      input  data_addr_ok, data_data_ok, data_rdata,
      input  sram_en, sram_we, sram_addr, sram_wdata,
      output sram_rdata
   );
endinterface

// File: rtl/sram_port_arbiter.sv
// Shares one synchronous SRAM port between fetch and load/store; data has priority.
// Define ARB_STARVE_GUARD_EN to bound fetch lock-out to STARVE_MAX lost arbitrations.
module sram_port_arbiter #(
   parameter int unsigned STARVE_MAX = 4
) (
   input logic             clk,
   input logic             resetn,
   sram_port_arbiter_if.slave bus
);

   if (STARVE_MAX < 1 || STARVE_MAX > 15) begin : g_bad_starve_max
      $error("STARVE_MAX must be in 1..15");
   end

   logic resp_valid_q, resp_valid_d;
   logic resp_owner_q, resp_owner_d;
   logic force_inst;
   logic grant_inst;
   logic grant_data;

`ifdef ARB_STARVE_GUARD_EN
   localparam logic [3:0] StarveMaxW = 4'(STARVE_MAX);

   logic [3:0] starve_cnt_q, starve_cnt_d;

   assign force_inst = bus.inst_req && (starve_cnt_q == StarveMaxW);

   always_comb begin
      starve_cnt_d = starve_cnt_q;
      if (!bus.inst_req || grant_inst) begin
         starve_cnt_d = 4'd0;
      end else if (bus.data_req && grant_data && (starve_cnt_q < StarveMaxW)) begin
         starve_cnt_d = starve_cnt_q + 4'd1;
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         starve_cnt_q <= 4'd0;
      end else begin
         starve_cnt_q <= starve_cnt_d;
      end
   end
`else
   assign force_inst = 1'b0;
`endif

   // Grants are masked by reset so every output reads zero while resetn is low.
   assign grant_data = resetn && bus.data_req && !force_inst;
   assign grant_inst = resetn && bus.inst_req && !grant_data;

   always_comb begin
      bus.inst_addr_ok = grant_inst;
      bus.data_addr_ok = grant_data;
      bus.sram_en      = 1'b0;
      bus.sram_we      = 4'b0000;
      bus.sram_addr    = 32'h0;
      bus.sram_wdata   = 32'h0;
      if (grant_data) begin
         bus.sram_en    = 1'b1;
         bus.sram_we    = bus.data_wr ? bus.data_wstrb : 4'b0000;
         bus.sram_addr  = bus.data_addr;
         bus.sram_wdata = bus.data_wdata;
      end else if (grant_inst) begin
         bus.sram_en    = 1'b1;
         bus.sram_addr  = bus.inst_addr;
      end
   end

   always_comb begin
      resp_valid_d = grant_inst || grant_data;
      resp_owner_d = grant_data;
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         resp_valid_q <= 1'b0;
         resp_owner_q <= 1'b0;
      end else begin
         resp_valid_q <= resp_valid_d;
         resp_owner_q <= resp_owner_d;
      end
   end

   assign bus.inst_data_ok = resp_valid_q && !resp_owner_q;
   assign bus.data_data_ok = resp_valid_q && resp_owner_q;
   assign bus.inst_rdata   = resetn ? bus.sram_rdata : 32'h0;
   assign bus.data_rdata   = resetn ? bus.sram_rdata : 32'h0;

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Directed bench for sram_port_arbiter: expected owners are queued at grant time
// and popped against the data_ok/rdata outputs one cycle later.
module tb_sram_port_arbiter;

   logic clk = 1'b0;
   logic resetn;
   int   n_vec = 0;
   int   n_err = 0;
   int   q[$];   // 0 = no response, 1 = inst, 2 = data

   sram_port_arbiter_if bus ();

   sram_port_arbiter #(
      .STARVE_MAX(4)
   ) dut (
      .clk   (clk),
      .resetn(resetn),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // One cycle: drive SRAM read data, check response and grant outputs, then clock.
   task automatic step(input int win, input logic [31:0] rd, input string tag);
      int          own;
      logic [31:0] exp_addr;
      logic [31:0] exp_wdata;
      logic [3:0]  exp_we;
      own = (q.size() != 0) ? q.pop_front() : 0;
      bus.sram_rdata = rd;
      #1;
      check({tag, ".inst_data_ok"}, 32'(bus.inst_data_ok), 32'(own == 1));
      check({tag, ".data_data_ok"}, 32'(bus.data_data_ok), 32'(own == 2));
      if (own == 1) check({tag, ".inst_rdata"}, bus.inst_rdata, rd);
      if (own == 2) check({tag, ".data_rdata"}, bus.data_rdata, rd);
      exp_addr  = (win == 1) ? bus.inst_addr : (win == 2) ? bus.data_addr : 32'h0;
      exp_wdata = (win == 2) ? bus.data_wdata : 32'h0;
      exp_we    = (win == 2 && bus.data_wr) ? bus.data_wstrb : 4'b0000;
      check({tag, ".inst_addr_ok"}, 32'(bus.inst_addr_ok), 32'(win == 1));
      check({tag, ".data_addr_ok"}, 32'(bus.data_addr_ok), 32'(win == 2));
      check({tag, ".sram_en"}, 32'(bus.sram_en), 32'(win != 0));
      check({tag, ".sram_addr"}, bus.sram_addr, exp_addr);
      check({tag, ".sram_we"}, 32'(bus.sram_we), 32'(exp_we));
      check({tag, ".sram_wdata"}, bus.sram_wdata, exp_wdata);
      q.push_back(win);
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, ".inst_addr_ok"}, 32'(bus.inst_addr_ok), 32'h0);
      check({tag, ".inst_data_ok"}, 32'(bus.inst_data_ok), 32'h0);
      check({tag, ".inst_rdata"}, bus.inst_rdata, 32'h0);
      check({tag, ".data_addr_ok"}, 32'(bus.data_addr_ok), 32'h0);
      check({tag, ".data_data_ok"}, 32'(bus.data_data_ok), 32'h0);
      check({tag, ".data_rdata"}, bus.data_rdata, 32'h0);
      check({tag, ".sram_en"}, 32'(bus.sram_en), 32'h0);
      check({tag, ".sram_we"}, 32'(bus.sram_we), 32'h0);
      check({tag, ".sram_addr"}, bus.sram_addr, 32'h0);
      check({tag, ".sram_wdata"}, bus.sram_wdata, 32'h0);
   endtask

   initial begin
      int guard_win[6];
      resetn         = 1'b0;
      bus.inst_req   = 1'b1;
      bus.inst_addr  = 32'h1C00_0040;
      bus.data_req   = 1'b1;
      bus.data_wr    = 1'b0;
      bus.data_wstrb = 4'b1111;
      bus.data_addr  = 32'h0000_0200;
      bus.data_wdata = 32'h1234_5678;
      bus.sram_rdata = 32'hA5A5_A5A5;

      // Reset holds everything low even with both requests pending.
      @(negedge clk);
      @(negedge clk);
      check_all_zero("reset");

      resetn = 1'b1;
      q.push_back(0);
      bus.inst_req = 1'b0;
      step(2, 32'h0, "rel_grant");
      bus.data_req = 1'b0;
      step(0, 32'h5555_AAAA, "rel_resp");

      // Fetch only.
      bus.inst_req  = 1'b1;
      bus.inst_addr = 32'h1C00_0000;
      step(1, 32'h0, "fetch_grant");
      bus.inst_req = 1'b0;
      step(0, 32'h0280_0C0C, "fetch_resp");

      // Partial store.
      bus.data_req   = 1'b1;
      bus.data_wr    = 1'b1;
      bus.data_wstrb = 4'b0011;
      bus.data_addr  = 32'h0000_0100;
      bus.data_wdata = 32'hDEAD_BEEF;
      step(2, 32'h0, "store_grant");
      bus.data_req = 1'b0;
      step(0, $urandom, "store_resp");

      // Both requesting for six cycles.
`ifdef ARB_STARVE_GUARD_EN
      guard_win = '{2, 2, 2, 2, 1, 2};
`else
      guard_win = '{2, 2, 2, 2, 2, 2};
`endif
      bus.data_wr   = 1'b0;
      bus.data_addr = 32'h0000_0300;
      bus.inst_addr = 32'h1C00_0010;
      bus.inst_req  = 1'b1;
      bus.data_req  = 1'b1;
      for (int i = 0; i < 6; i++) begin
         step(guard_win[i], $urandom, $sformatf("both%0d", i + 1));
      end
      bus.inst_req = 1'b0;
      bus.data_req = 1'b0;
      step(0, $urandom, "both_tail");

      // Alternating owners back-to-back.
      bus.data_req = 1'b1;
      bus.data_addr = 32'h0000_0404;
      step(2, $urandom, "alt_d1");
      bus.data_req = 1'b0;
      bus.inst_req = 1'b1;
      bus.inst_addr = 32'h1C00_0020;
      step(1, $urandom, "alt_i");
      bus.inst_req = 1'b0;
      bus.data_req = 1'b1;
      bus.data_wr  = 1'b1;
      bus.data_wstrb = 4'b1100;
      bus.data_wdata = 32'hCAFE_F00D;
      step(2, $urandom, "alt_d2");
      bus.data_req = 1'b0;
      bus.data_wr  = 1'b0;
      step(0, $urandom, "alt_tail");

      // Reset while a load response is in flight.
      bus.data_req  = 1'b1;
      bus.data_addr = 32'h0000_0500;
      step(2, $urandom, "rst_load");
      bus.data_req = 1'b0;
      resetn = 1'b0;
      #1;
      check("rst_mid.data_data_ok", 32'(bus.data_data_ok), 32'h0);
      q.delete();
      @(negedge clk);
      resetn = 1'b1;
      q.push_back(0);
      step(0, $urandom, "rst_after");
      step(0, $urandom, "rst_idle");

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
